// File: rtl/mem_result_queue.sv
// mem_result_queue: in-order buffer of completed d-cache accesses between the
// memory stage and writeback/commit. Valid/ready on the drain side, full and
// sticky overflow on the fill side, and a single-cycle flush that empties it.
module mem_result_queue #(
  parameter int DEPTH      = 4,   // power of two, >= 2
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_valid,
  input  logic                     i_nop,
  input  logic                     i_is_store,
  input  logic [DATA_WIDTH-1:0]    i_data,
  input  logic [ID_WIDTH-1:0]      i_dispatch_index,
  input  logic                     i_flush,
  output logic                     o_full,
  output logic                     o_valid,
  output logic                     o_is_store,
  output logic [DATA_WIDTH-1:0]    o_data,
  output logic [ID_WIDTH-1:0]      o_dispatch_index,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic                  is_store;
    logic [DATA_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   idx;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          wr_entry;
  entry_t          head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            overflow;
  logic            offer, push, pop;

  // Status decoded from registers only; no input-to-output combinational path.
  assign o_full  = (count == CW'(DEPTH));
  assign o_valid = (count != '0);

  // A flush cycle swallows both sides; a full queue refuses even if popping.
  assign offer = i_valid && !i_nop;
  assign push  = offer && !o_full && !i_flush;
  assign pop   = o_valid && i_ready && !i_flush;

  assign wr_entry = '{is_store: i_is_store, data: i_data, idx: i_dispatch_index};

  // Entry storage; cleared on reset so the head never reads X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky protocol error: upstream offered an entry while we were full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          overflow <= 1'b0;
    else if (offer && o_full && !i_flush) overflow <= 1'b1;
  end

  assign head             = mem[rd_ptr];
  assign o_is_store       = head.is_store;
  assign o_data           = head.data;
  assign o_dispatch_index = head.idx;
  assign o_count          = count;
  assign o_overflow       = overflow;

endmodule

// File: doc/mem_result_queue.md
# mem_result_queue

Buffers completed d-cache accesses between the memory stage and the writeback/commit stage. It takes one result per cycle from the registered d-cache output. It presents results in order to the writeback arbiter through a valid/ready handshake. It raises a full signal that the hazard unit folds into the memory-stage stall. On a misprediction flush it discards every buffered result.

## Interface

Parameters:
- DEPTH, 4, number of entries; must be a power of two and at least 2.
- DATA_WIDTH, 32, width of load data.
- ID_WIDTH, 6, width of the dispatch/active-list index carried with each result.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- i_valid, in, 1, d-cache output holds a completed access this cycle.
- i_nop, in, 1, the access has been invalidated; do not enqueue it.
- i_is_store, in, 1, 0 = READ, 1 = WRITE.
- i_data, in, DATA_WIDTH, load data; ignored for stores.
- i_dispatch_index, in, ID_WIDTH, tag of the instruction.
- i_flush, in, 1, misprediction invalidate; empties the queue.
- o_full, out, 1, count == DEPTH; upstream must not present a new entry.
- o_valid, out, 1, head entry available.
- o_is_store, out, 1, is_store field of the head entry.
- o_data, out, DATA_WIDTH, data field of the head entry.
- o_dispatch_index, out, ID_WIDTH, index field of the head entry.
- i_ready, in, 1, writeback consumes the head when o_valid && i_ready.
- o_count, out, $clog2(DEPTH)+1, occupancy.
- o_overflow, out, 1, sticky protocol-error flag.

## Operation

- Circular buffer of DEPTH entries. Each entry holds {is_store, data, dispatch_index}.
- Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH. Count is a separate register.
- push = i_valid && !i_nop && !o_full && !i_flush.
  - On push, write the entry at wr_ptr and increment wr_ptr.
- pop = o_valid && i_ready && !i_flush.
  - On pop, increment rd_ptr.
- Count update:
  - count += push − pop.
  - Push and pop in the same cycle leave count unchanged, including when count == 1.
- Full:
  - o_full = (count == DEPTH).
  - A push is refused when full, even if a pop happens in the same cycle. There is no fall-through.
- Empty:
  - o_valid = (count != 0).
  - Head outputs are don't-care when o_valid = 0 but must not be X after reset.
- Flush (i_flush = 1):
  - Next cycle, wr_ptr = rd_ptr = 0 and count = 0.
  - Any push or pop in that cycle is ignored.
  - The writeback side must treat a head presented during a flush cycle as not consumed.
- Overflow:
  - o_overflow is set when i_valid && !i_nop && o_full && !i_flush.
  - It stays set until reset. The offered entry is dropped and queue state is unchanged.
- Stores are queued like loads so that commit sees completion in program order. o_data for a store is the enqueued i_data value, unmodified.

## Timing

- Reset (asynchronous, while rst_n = 0):
  - wr_ptr = rd_ptr = 0, count = 0.
  - o_valid = 0, o_full = 0, o_count = 0, o_overflow = 0.
  - Entry storage is cleared to 0, so head outputs read 0.
- Reset deassertion mid-operation: all prior contents are lost. The first push after release is accepted on the first rising edge with rst_n = 1.
- Latency: an entry pushed at edge N is visible at the head with o_valid = 1 in the cycle after edge N, provided the queue was empty. There is no combinational path from i_* to o_valid or to head data.
- o_full, o_valid and o_count are decoded from registers only. They do not depend combinationally on i_valid or i_ready.
- Throughput: one push and one pop per cycle sustained.
- Head outputs stay stable while o_valid && !i_ready, unless i_flush is asserted.

## Test plan

- Reset and single load:
  - Assert rst_n = 0 mid-cycle → all outputs go to 0 immediately.
  - Release reset, push load {data = 0xDEADBEEF, idx = 5} → next cycle o_valid = 1, o_data = 0xDEADBEEF, o_dispatch_index = 5.
  - Assert i_ready → o_valid = 0 the following cycle.
- Fill, wrap and overflow with DEPTH = 4, i_ready = 0:
  - Push idx 1–4 → o_full = 1, o_count = 4.
  - Push idx 5 → o_overflow = 1 and stays 1; count stays 4.
  - Pop all → order 1, 2, 3, 4.
  - Push idx 6–9 → popped in order 6–9, confirming pointer wrap-around.
- Full with simultaneous push and pop:
  - Queue full, i_ready = 1, push offered → pop occurs and push is refused.
  - Next cycle o_count = 3, o_full = 0; o_overflow is set because the push was offered while full.
- Streaming at occupancy 1:
  - Push every cycle with i_ready = 1 continuously for 20 results → o_count holds at 1.
  - Every index appears exactly once, in order.
- Flush:
  - With 3 entries queued, assert i_flush together with a push and i_ready → next cycle o_count = 0, o_valid = 0.
  - The flushed-cycle push never appears.
  - A push on the next cycle appears at the head with the correct data.
- NOP filtering:
  - Offer i_valid = 1 with i_nop = 1 for idx 7, then a normal push for idx 8 → only idx 8 is ever presented.
  - o_count never exceeds 1.
